mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle multiply/divide responder for the MIPS core.
- The control unit is the initiator: it pulses start with an operation code and the A/B register values, waits on busy/done, then reads HI/LO through the writeback mux (mfhi/mflo).
- The unit also accepts direct HI/LO writes (mthi/mtlo).
- Iterative radix-2 datapath: one bit per cycle, fixed latency.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  00=mult, 01=div, 10=multu, 11=divu (see Optional Feature)
- a  in  WIDTH  rs value (multiplicand / dividend)
- b  in  WIDTH  rt value (multiplier / divisor)
- hi_wr  in  1  mthi strobe
- lo_wr  in  1  mtlo strobe
- wdata  in  WIDTH  data for hi_wr/lo_wr
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_zero  out  1  last divide had b==0; sticky until next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0 latches op, the operand magnitudes and the result signs.
  - counter=WIDTH, busy=1, state goes to CALC.
  - div_zero is cleared, or set at E0 if the op is a divide and b==0.
- CALC: one iteration per edge (E1..E32). Counter decrements; when it reaches 0 the state goes to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on the remainder/quotient registers.
- FIX, edge E33:
  - Apply sign correction; write hi/lo; done=1 for exactly one cycle; busy=0; state goes to IDLE.
  - Total latency: done is visible in the cycle after E33, i.e. 33 edges after the accepted start.
- Result rules:
  - mult: {hi,lo} = signed 2*WIDTH-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps; no trap).
  - Divide by zero: full latency is still taken, hi/lo are left unchanged, done pulses, div_zero=1.
- Handshake:
  - start while busy=1 is ignored; the in-flight operation is unaffected.
  - start in the same cycle done=1 is accepted (the state is IDLE at that edge).
  - a/b need only be valid at the accepting edge.
- hi_wr/lo_wr:
  - Honoured only when busy=0 and not in FIX; they write wdata at the edge.
  - While busy they are ignored.
  - In IDLE, if start and hi_wr/lo_wr occur together, the write happens this edge and the started op later overwrites both registers.
- Reset mid-operation aborts immediately: all reset values, no done pulse.
- hi/lo hold their value between operations; they are not cleared by start.

Optional Feature:
- Macro: MDU_UNSIGNED_EN.
- Defined: op 10 (multu) and 11 (divu) treat a/b as unsigned, with no sign correction in FIX.
- Undefined: op[1] is ignored; 10 behaves as mult and 11 as div. The unsigned sign-bypass logic is not synthesised.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=5 -> done exactly 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 32 cycles.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_zero=0.
- div a=100, b=0 -> done after 33 edges, hi/lo unchanged from the prior values, div_zero=1; a following mult 6*7 clears div_zero, giving lo=42, hi=0.
- start pulse at cycle 10 of an in-flight mult, with different operands -> ignored; the original result is returned; hi_wr during busy is ignored.
- Assert rst at cycle 15 of a div -> busy=0, hi=lo=0 immediately, no done pulse; a new start then completes normally.
- With MDU_UNSIGNED_EN: multu 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE. Without it: same op gives hi=0xFFFFFFFF, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Define MDU_UNSIGNED_EN to make op[1] select multu/divu.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_p;
  logic             neg_r;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    acc_nxt;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rmd;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef MDU_UNSIGNED_EN
  assign sgn = ~op[1];
`else
  // op[1] has no effect in this build
  assign sgn = 1'b1 | op[1];
`endif

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // mult: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    diff = acc[W2-1:WIDTH-1] - {1'b0, mb};
    if (!is_div)
      acc_nxt = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {acc[W2-2:0], 1'b0};
  end

  always_comb begin
    prod   = neg_p ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rmd    = acc[W2-1:WIDTH];
    res_lo = is_div ? (neg_p ? -quo : quo) : prod[WIDTH-1:0];
    res_hi = is_div ? (neg_r ? -rmd : rmd) : prod[W2-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      ma       <= '0;
      mb       <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hi_wr) hi <= wdata;
          if (lo_wr) lo <= wdata;
          if (start) begin
            is_div   <= op[0];
            neg_p    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            ma       <= a_mag;
            mb       <= b_mag;
            acc      <= {{WIDTH{1'b0}}, op[0] ? a_mag : b_mag};
            div_zero <= op[0] && (b == '0);
            cnt      <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= FIX;
          end
        end
        FIX: begin
          if (!div_zero) begin
            hi <= res_hi;
            lo <= res_lo;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit against a
// cycle-count behavioural model of the HI/LO results.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Architectural result of one operation
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y, output logic [31:0] rh,
                                 output logic [31:0] rl, output logic dz);
    logic s;
    longint sx, sy, q, r;
    logic [63:0] ux, uy, p;
`ifdef MDU_UNSIGNED_EN
    s = !o[1];
`else
    s = 1'b1;
`endif
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    dz = 1'b0;
    rh = '0;
    rl = '0;
    if (!o[0]) begin
      ux = sx;
      uy = sy;
      p  = ux * uy;
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == 0) begin
      dz = 1'b1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  // Model: edges remaining until the result lands (0 = idle)
  int          m_rem = 0;
  logic        m_done = 0;
  logic        m_dz = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [31:0] p_hi = 0;
  logic [31:0] p_lo = 0;
  logic        p_dz = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  = 0;
      m_done = 0;
      m_dz   = 0;
      m_hi   = 0;
      m_lo   = 0;
    end else begin
      m_done = 0;
      if (m_rem == 0) begin
        if (hi_wr) m_hi = wdata;
        if (lo_wr) m_lo = wdata;
        if (start) begin
          ref_op(op, a, b, p_hi, p_lo, p_dz);
          m_dz  = p_dz;
          m_rem = 33;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1;
          if (!m_dz) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("busy", busy, m_rem > 1);
      check("done", done, m_done);
      check("div_zero", div_zero, m_dz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE; optionally inject start+writes at edge count inj
  task automatic run_op(input logic [1:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, input int inj,
                        output int n, output int bcnt);
    start = 1;
    op    = o;
    a     = xa;
    b     = xb;
    tick();
    start = 0;
    a     = $urandom;
    b     = $urandom;
    n     = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && n < 100) begin
      if (inj != 0 && n == inj) begin
        start = 1;
        op    = o ^ 2'b01;
        hi_wr = 1;
        lo_wr = 1;
        wdata = 32'hDEAD_BEEF;
      end
      tick();
      start = 0;
      hi_wr = 0;
      lo_wr = 0;
      n++;
      if (busy) bcnt++;
    end
    if (!done) check("done_timeout", done, 1'b1);
  endtask

  int n, bc;

  initial begin
    rst   = 1;
    start = 0;
    op    = 0;
    a     = 0;
    b     = 0;
    hi_wr = 0;
    lo_wr = 0;
    wdata = 0;
    repeat (3) tick();
    check_en = 1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", div_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 0;
    tick();

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, n, bc);
    check("mult_latency", n, 33);
    check("mult_busy_cycles", bc, 32);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    tick();

    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 0, n, bc);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_dz", div_zero, 1'b0);
    tick();

    hi_wr = 1;
    wdata = 32'hAAAA_5555;
    tick();
    hi_wr = 0;
    lo_wr = 1;
    wdata = 32'h1234_5678;
    tick();
    lo_wr = 0;
    run_op(2'b01, 32'd100, 32'd0, 0, n, bc);
    check("dz_latency", n, 33);
    check("dz_hi", hi, 32'hAAAA_5555);
    check("dz_lo", lo, 32'h1234_5678);
    check("dz_flag", div_zero, 1'b1);
    // start issued in the done cycle
    run_op(2'b00, 32'd6, 32'd7, 0, n, bc);
    check("m67_lo", lo, 32'd42);
    check("m67_hi", hi, 32'd0);
    check("m67_dz", div_zero, 1'b0);
    tick();

    run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 10, n, bc);
    check("inj_latency", n, 33);
    check("inj_hi", hi, 32'hFFFF_FFFF);
    check("inj_lo", lo, 32'hFFFF_F448);
    tick();

    start = 1;
    op    = 2'b01;
    a     = 32'd1000;
    b     = 32'd7;
    tick();
    start = 0;
    repeat (14) tick();
    rst = 1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_done", done, 1'b0);
    tick();
    tick();
    rst = 0;
    tick();
    run_op(2'b01, 32'd20, 32'd3, 0, n, bc);
    check("post_rst_lo", lo, 32'd6);
    check("post_rst_hi", hi, 32'd2);
    tick();

    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 0, n, bc);
`ifdef MDU_UNSIGNED_EN
    check("multu_hi", hi, 32'h1);
`else
    check("multu_hi", hi, 32'hFFFF_FFFF);
`endif
    check("multu_lo", lo, 32'hFFFF_FFFE);
    tick();

    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, n, bc);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);
    tick();

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 4) == 0;
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      hi_wr = ($urandom % 8) == 0;
      lo_wr = ($urandom % 8) == 0;
      wdata = $urandom;
      rst   = ($urandom % 1000) == 0;
      tick();
    end
    start = 0;
    hi_wr = 0;
    lo_wr = 0;
    rst   = 0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
